// File: rtl/pulse_train_gen.sv
// -----------------------------------------------------------------------------
// pulse_train_gen
//
// Turns one accepted single-cycle trigger into a programmable pulse train:
// a start delay, then `repeat` pulses of `width` high cycles separated by
// `gap` low cycles. A repeat of 0 runs the train until enable drops.
// Configuration is latched when a trigger is accepted, so the cfg_* inputs
// may change freely while a train runs.
//
// Optional feature (macro PULSE_TRAIN_GEN_RETRIGGER_EN):
//   when defined, a trigger while busy restarts the train from scratch
//   (re-latches cfg_*, clears pulse_cnt, no done for the aborted train).
//   When undefined, triggers while busy are ignored.
//
// Ports:
//   clk_in      system clock, rising edge
//   reset       asynchronous active-high reset
//   enable      block enable; low aborts any train and blocks triggers
//   trig_in     single-cycle trigger pulse
//   cfg_delay   cycles from trigger sample to first rising edge of out
//   cfg_width   high cycles per pulse (0 treated as 1)
//   cfg_gap     low cycles between pulses (0 treated as 1)
//   cfg_repeat  pulses per train (0 = continuous)
//   out         registered pulse-train output
//   busy        high while a train is in progress
//   done        one-cycle pulse when a finite train completes
//   pulse_cnt   pulses emitted in the current/last train (wraps)
// -----------------------------------------------------------------------------
module pulse_train_gen #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 trig_in,
    input  logic [CNT_WIDTH-1:0] cfg_delay,
    input  logic [CNT_WIDTH-1:0] cfg_width,
    input  logic [CNT_WIDTH-1:0] cfg_gap,
    input  logic [CNT_WIDTH-1:0] cfg_repeat,
    output logic                 out,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] pulse_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        GAP   = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] ZERO = '0;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0] pulse_cnt_q, pulse_cnt_d;
    logic [CNT_WIDTH-1:0] delay_q, delay_d;
    logic [CNT_WIDTH-1:0] width_q, width_d;
    logic [CNT_WIDTH-1:0] gap_q, gap_d;
    logic [CNT_WIDTH-1:0] repeat_q, repeat_d;
    logic                 out_q, out_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 accept;
    logic [CNT_WIDTH-1:0] pulse_inc;

    // A trigger is taken only from IDLE unless retriggering is built in.
`ifdef PULSE_TRAIN_GEN_RETRIGGER_EN
    assign accept = trig_in && enable;
`else
    assign accept = trig_in && enable && (state_q == IDLE);
`endif

    assign pulse_inc = pulse_cnt_q + ONE;

    // cnt_q counts cycles already spent in the current state, starting at 1
    // on the entry edge, so leaving when cnt_q equals the programmed length
    // gives exactly that many cycles without ever needing a value above the
    // configured maximum.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pulse_cnt_d = pulse_cnt_q;
        delay_d     = delay_q;
        width_d     = width_q;
        gap_d       = gap_q;
        repeat_d    = repeat_q;
        out_d       = out_q;
        done_d      = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            out_d   = 1'b0;
            cnt_d   = ZERO;
        end else if (accept) begin
            delay_d     = cfg_delay;
            width_d     = (cfg_width == ZERO) ? ONE : cfg_width;
            gap_d       = (cfg_gap == ZERO) ? ONE : cfg_gap;
            repeat_d    = cfg_repeat;
            pulse_cnt_d = ZERO;
            cnt_d       = ONE;
            if (cfg_delay == ZERO) begin
                state_d = HIGH;
                out_d   = 1'b1;
            end else begin
                state_d = DELAY;
                out_d   = 1'b0;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = ZERO;
                end
                DELAY: begin
                    if (cnt_q == delay_q) begin
                        state_d = HIGH;
                        out_d   = 1'b1;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                HIGH: begin
                    if (cnt_q == width_q) begin
                        out_d       = 1'b0;
                        pulse_cnt_d = pulse_inc;
                        if ((repeat_q != ZERO) && (pulse_inc == repeat_q)) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                            cnt_d   = ZERO;
                        end else begin
                            state_d = GAP;
                            cnt_d   = ONE;
                        end
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                GAP: begin
                    if (cnt_q == gap_q) begin
                        state_d = HIGH;
                        out_d   = 1'b1;
                        cnt_d   = ONE;
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    out_d   = 1'b0;
                    cnt_d   = ZERO;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= ZERO;
            pulse_cnt_q <= ZERO;
            delay_q     <= ZERO;
            width_q     <= ZERO;
            gap_q       <= ZERO;
            repeat_q    <= ZERO;
            out_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pulse_cnt_q <= pulse_cnt_d;
            delay_q     <= delay_d;
            width_q     <= width_d;
            gap_q       <= gap_d;
            repeat_q    <= repeat_d;
            out_q       <= out_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign out       = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pulse_cnt = pulse_cnt_q;

endmodule

// File: tb/tb_pulse_train_gen.sv
// -----------------------------------------------------------------------------
// tb_pulse_train_gen
//
// Directed bench for pulse_train_gen. Inputs are driven 1 time unit after a
// rising edge; outputs are sampled at the same point, i.e. they show the
// register values loaded by the edge just taken. Offset t in each loop is the
// edge at which the trigger (t = 0) was sampled, plus t.
// -----------------------------------------------------------------------------
module tb_pulse_train_gen;

    localparam int CW = 16;

`ifdef PULSE_TRAIN_GEN_RETRIGGER_EN
    localparam bit RETRIG = 1'b1;
`else
    localparam bit RETRIG = 1'b0;
`endif

    logic          clk_in = 1'b0;
    logic          reset;
    logic          enable;
    logic          trig_in;
    logic [CW-1:0] cfg_delay;
    logic [CW-1:0] cfg_width;
    logic [CW-1:0] cfg_gap;
    logic [CW-1:0] cfg_repeat;
    logic          out;
    logic          busy;
    logic          done;
    logic [CW-1:0] pulse_cnt;

    int checks = 0;
    int errors = 0;

    pulse_train_gen #(.CNT_WIDTH(CW)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .enable     (enable),
        .trig_in    (trig_in),
        .cfg_delay  (cfg_delay),
        .cfg_width  (cfg_width),
        .cfg_gap    (cfg_gap),
        .cfg_repeat (cfg_repeat),
        .out        (out),
        .busy       (busy),
        .done       (done),
        .pulse_cnt  (pulse_cnt)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
        end else begin
            $display("ok   %s = %0h", tag, obs);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic set_cfg(input logic [CW-1:0] d, input logic [CW-1:0] w,
                           input logic [CW-1:0] g, input logic [CW-1:0] r);
        cfg_delay  = d;
        cfg_width  = w;
        cfg_gap    = g;
        cfg_repeat = r;
    endtask

    initial begin
        int s;
        int n;
        int rel;
        bit exp_out;

        reset   = 1'b1;
        enable  = 1'b1;
        trig_in = 1'b0;
        set_cfg(16'd0, 16'd0, 16'd0, 16'd0);
        #1;
        check("rst_out", {31'd0, out}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_pcnt", {16'd0, pulse_cnt}, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // ---- delay 3, width 2, gap 4, repeat 3; extra trigger at t=1 in
        // DELAY and cfg change while busy; extra trigger on the done edge.
        set_cfg(16'd3, 16'd2, 16'd4, 16'd3);
        s = RETRIG ? 1 : 0;
        for (int t = 0; t <= 18 + s; t++) begin
            trig_in = (t == 0) || (t == 1) || (!RETRIG && (t == 17));
            cfg_delay = (t >= 2) ? 16'd7 : 16'd3;
            tick();
            rel = t - s;
            exp_out = (rel == 3) || (rel == 4) || (rel == 9) || (rel == 10) ||
                      (rel == 15) || (rel == 16);
            check($sformatf("a_out_t%0d", t), {31'd0, out}, {31'd0, exp_out});
            check($sformatf("a_busy_t%0d", t), {31'd0, busy}, {31'd0, t <= 16 + s});
            check($sformatf("a_done_t%0d", t), {31'd0, done}, {31'd0, t == 17 + s});
            if (t == 1) check("a_pcnt_t1", {16'd0, pulse_cnt}, 32'd0);
            if (t == 11 + s) check("a_pcnt_mid", {16'd0, pulse_cnt}, 32'd2);
            if (t == 17 + s) check("a_pcnt_end", {16'd0, pulse_cnt}, 32'd3);
        end
        trig_in = 1'b0;
        tick();

        // ---- delay 0, width 0, gap 0, repeat 2; trigger on the done edge
        // (ignored without retrigger) and on the edge after (accepted).
        set_cfg(16'd0, 16'd0, 16'd0, 16'd2);
        for (int t = 0; t <= 8; t++) begin
            trig_in = (t == 0) || (!RETRIG && (t == 3)) || (t == 4);
            tick();
            check($sformatf("b_out_t%0d", t), {31'd0, out},
                  {31'd0, (t == 0) || (t == 2) || (t == 4) || (t == 6)});
            check($sformatf("b_done_t%0d", t), {31'd0, done}, {31'd0, (t == 3) || (t == 7)});
            check($sformatf("b_busy_t%0d", t), {31'd0, busy},
                  {31'd0, (t <= 2) || ((t >= 4) && (t <= 6))});
            if (t == 3) check("b_pcnt_done", {16'd0, pulse_cnt}, 32'd2);
            if (t == 4) check("b_pcnt_clr", {16'd0, pulse_cnt}, 32'd0);
        end
        trig_in = 1'b0;

        // ---- continuous, width 1, gap 1; enable dropped after 10 pulses
        set_cfg(16'd0, 16'd1, 16'd1, 16'd0);
        for (int t = 0; t <= 19; t++) begin
            trig_in = (t == 0);
            tick();
            check($sformatf("c_out_t%0d", t), {31'd0, out}, {31'd0, (t % 2) == 0});
            check($sformatf("c_done_t%0d", t), {31'd0, done}, 32'd0);
            if (t % 4 == 3) check($sformatf("c_pcnt_t%0d", t), {16'd0, pulse_cnt}, (t + 1) / 2);
        end
        trig_in = 1'b0;
        enable  = 1'b0;
        tick();
        check("c_en_out", {31'd0, out}, 32'd0);
        check("c_en_busy", {31'd0, busy}, 32'd0);
        check("c_en_done", {31'd0, done}, 32'd0);
        check("c_en_pcnt", {16'd0, pulse_cnt}, 32'd10);
        trig_in = 1'b1;
        tick();
        check("c_dis_trig_busy", {31'd0, busy}, 32'd0);
        check("c_dis_trig_pcnt", {16'd0, pulse_cnt}, 32'd10);
        trig_in = 1'b0;
        enable  = 1'b1;
        tick();

        // ---- asynchronous reset in the middle of a HIGH cycle
        set_cfg(16'd0, 16'd1, 16'd1, 16'd0);
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        for (int t = 1; t <= 4; t++) tick();
        check("d_pre_out", {31'd0, out}, 32'd1);
        check("d_pre_pcnt", {16'd0, pulse_cnt}, 32'd2);
        #2;
        reset = 1'b1;
        #1;
        check("d_rst_out", {31'd0, out}, 32'd0);
        check("d_rst_busy", {31'd0, busy}, 32'd0);
        check("d_rst_done", {31'd0, done}, 32'd0);
        check("d_rst_pcnt", {16'd0, pulse_cnt}, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        check("d_post_done", {31'd0, done}, 32'd0);
        check("d_post_busy", {31'd0, busy}, 32'd0);

        // ---- maximum delay, width 1, repeat 1
        set_cfg(16'hFFFF, 16'd1, 16'd1, 16'd1);
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        check("e_busy", {31'd0, busy}, 32'd1);
        n = 0;
        while ((out == 1'b0) && (n < 70000)) begin
            tick();
            n++;
        end
        check("e_rise_latency", n, 32'd65535);
        tick();
        check("e_done", {31'd0, done}, 32'd1);
        check("e_out_fall", {31'd0, out}, 32'd0);
        check("e_pcnt", {16'd0, pulse_cnt}, 32'd1);
        tick();
        check("e_done_1cyc", {31'd0, done}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_train_gen.md
Name: pulse_train_gen

Overview:
- Downstream consumer of the single-cycle rising-edge pulse generator.
- Each accepted trigger pulse produces a programmable train of output pulses: start delay, high width, low gap and repeat count.
- Used to turn a cleaned, edge-detected strobe into injection, strobe or gate sequences for front-end chips.
- Single clock domain; configuration inputs are quasi-static and latched at trigger acceptance.

Parameters:
- CNT_WIDTH, 16, bit width of the delay, width, gap and repeat counters and configuration inputs.

Ports:
- clk_in  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  block enable; low aborts any train and blocks triggers.
- trig_in  input  1  single-cycle trigger pulse from the rising-edge generator.
- cfg_delay  input  CNT_WIDTH  cycles from trigger sample to first rising edge of out.
- cfg_width  input  CNT_WIDTH  high time per pulse in cycles; 0 treated as 1.
- cfg_gap  input  CNT_WIDTH  low time between pulses in cycles; 0 treated as 1.
- cfg_repeat  input  CNT_WIDTH  pulses per train; 0 = continuous until enable drops.
- out  output  1  registered pulse-train output.
- busy  output  1  high while a train is in progress.
- done  output  1  one-cycle pulse when a finite train completes.
- pulse_cnt  output  CNT_WIDTH  pulses emitted in the current or last train; wraps modulo 2^CNT_WIDTH.

Behaviour:
- Reset:
  - Asynchronous assertion forces state IDLE, out=0, busy=0, done=0, pulse_cnt=0, all counters 0.
  - Reset mid-train aborts the train immediately, with no done.
- FSM states: IDLE, DELAY, HIGH, GAP. All outputs are registered.
- IDLE:
  - Condition: trig_in=1 and enable=1 at edge k.
  - Action at edge k: latch all cfg_*, set busy=1, clear pulse_cnt.
  - If cfg_delay=0, go to HIGH with out=1 at edge k; otherwise go to DELAY.
- Timing:
  - out rises at edge k+cfg_delay and stays high exactly max(cfg_width,1) cycles.
  - Latency from trigger sample to out=1 equals cfg_delay cycles; minimum 0 extra cycles.
- HIGH end:
  - pulse_cnt increments on the edge where out falls.
  - If latched repeat≠0 and this was pulse number repeat: go to IDLE, out=0, busy=0, done=1 for one cycle, all on the same edge.
  - Otherwise go to GAP.
- GAP:
  - out stays low for max(cfg_gap,1) cycles, then returns to HIGH.
  - Pulse period is width+gap.
- Triggers and configuration:
  - trig_in while busy is ignored; no queuing.
  - cfg_* changes while busy have no effect until the next accepted trigger.
- enable:
  - enable=0 in any state goes to IDLE on the next edge: out=0, busy=0, no done.
  - pulse_cnt holds its value.
- Simultaneous events:
  - Trigger on the same edge that done is asserted is ignored, because the block is still busy that cycle.
  - Trigger on the following edge is accepted.
- Continuous mode: with cfg_repeat=0 the train never completes and done is never asserted; pulse_cnt wraps.
- Width rules: counters are CNT_WIDTH bits, compared with equality; no overflow on a maximum-value config.

Optional Feature:
- Macro: PULSE_TRAIN_GEN_RETRIGGER_EN.
- Defined:
  - trig_in with enable=1 while busy restarts the train at that edge: re-latch cfg_*, clear pulse_cnt, state DELAY/HIGH as from IDLE, out forced low for DELAY entry.
  - No done is issued for the aborted train.
- Undefined: triggers while busy are ignored, as above.

Test Plan:
- Reset asserted asynchronously mid-HIGH -> out, busy, done, pulse_cnt all 0 immediately, with no clock edge required.
- delay=3, width=2, gap=4, repeat=3, trigger at edge 10 -> out high during edges 13–14, 19–20, 25–26. Same edge (27): busy 0, done 1 for one cycle, pulse_cnt=3.
- delay=0, width=0, gap=0, repeat=2, trigger at edge 5 -> out high at edge 5 for 1 cycle, low 1 cycle, high 1 cycle; done at edge 8.
- repeat=0, width=1, gap=1, enable dropped after 10 pulses -> out toggles every cycle; enable low ends the train next edge with no done, pulse_cnt=10.
- Trigger again during DELAY and on the done edge -> ignored, train unchanged. With PULSE_TRAIN_GEN_RETRIGGER_EN: trigger during DELAY restarts delay count and pulse_cnt=0.
- Max config: delay=0xFFFF, width=1, repeat=1 (CNT_WIDTH=16) -> out rises exactly 65535 cycles after trigger; done one cycle after it rises.
